// File: rtl/usb_sdram_pkg.sv
// State encoding and shared constants for the USB half-word to SDRAM frame writer.
package usb_sdram_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FILL_LO  = 4'd1,
        S_FILL_HI  = 4'd2,
        S_REQ      = 4'd3,
        S_WAIT_ACK = 4'd4,
        S_RECOVER  = 4'd5,
        S_DONE     = 4'd6
    } state_e;

    localparam logic [3:0] SEL_ALL            = 4'hF;
    localparam int         DEFAULT_WORD_COUNT = 120;

endpackage

// File: rtl/usb_sdram_writer_hw_packer.sv
// Assembles two consecutive 16-bit half-words (low first) into one 32-bit word.
module hw_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        ld_lo_i,
    input  logic        ld_hi_i,
    input  logic [15:0] hw_i,
    output logic [31:0] word_o,
    output logic        phase_o
);

    logic [31:0] word_q;
    logic        phase_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q  <= '0;
            phase_q <= 1'b0;
        end else if (clr_i) begin
            word_q  <= '0;
            phase_q <= 1'b0;
        end else if (ld_lo_i) begin
            word_q[15:0] <= hw_i;
            phase_q      <= 1'b1;
        end else if (ld_hi_i) begin
            word_q[31:16] <= hw_i;
            phase_q       <= 1'b0;
        end
    end

    assign word_o  = word_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/usb_sdram_writer.sv
// Packs a USB half-word stream into 32-bit words and writes one frame to SDRAM over classic Wishbone.
// Optional WB_TIMEOUT_EN aborts a bus cycle that receives no acknowledge within TIMEOUT cycles.
module usb_sdram_writer
    import usb_sdram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          WORD_COUNT = DEFAULT_WORD_COUNT,
    parameter int          TIMEOUT    = 64
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        cyc_i,
    output logic        stb_i,
    output logic        we_i,
    output logic [3:0]  sel_i,
    output logic [31:0] addr_i,
    output logic [31:0] data_i,
    input  logic [31:0] data_o,
    input  logic        stall_o,
    input  logic        sdram_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  dbg_state_o
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        armed_q, armed_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cyc_q, cyc_d;
    logic [3:0]  sel_q, sel_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        pk_clr, pk_ld_lo, pk_ld_hi, pk_phase;
    logic [31:0] pk_word;
    logic        to_hit;

`ifdef WB_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    // Counts cycles spent in WAIT_ACK; restarts on every new bus cycle.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == S_WAIT_ACK) begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign to_hit = (to_cnt_q == 32'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign to_hit = 1'b0;
`endif

    hw_packer u_packer (
        .clk_i   (CLK),
        .rst_i   (rst),
        .clr_i   (pk_clr),
        .ld_lo_i (pk_ld_lo),
        .ld_hi_i (pk_ld_hi),
        .hw_i    (in_data),
        .word_o  (pk_word),
        .phase_o (pk_phase)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        armed_d  = armed_q;
        done_d   = done_q;
        err_d    = err_q;
        pk_clr   = 1'b0;
        pk_ld_lo = 1'b0;
        pk_ld_hi = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL_LO;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = BASE_ADDR;
                    wcnt_d  = '0;
                    pk_clr  = 1'b1;
                end
            end
            S_FILL_LO: begin
                if (in_valid) begin
                    pk_ld_lo = 1'b1;
                    state_d  = S_FILL_HI;
                end
            end
            S_FILL_HI: begin
                if (in_valid) begin
                    pk_ld_hi = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                armed_d = 1'b0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // The slave's ack lags cyc by a cycle, so only an ack preceded by a low cycle counts.
                if (!sdram_ack) begin
                    armed_d = 1'b1;
                end
                if (sdram_ack && armed_q) begin
                    addr_d  = addr_q + 32'd1;
                    wcnt_d  = wcnt_q + 16'd1;
                    state_d = S_RECOVER;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RECOVER: begin
                if (wcnt_q == 16'(WORD_COUNT)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL_LO;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Bus and handshake outputs are registered images of the next state.
        cyc_d      = (state_d == S_WAIT_ACK);
        sel_d      = cyc_d ? SEL_ALL : 4'h0;
        in_ready_d = (state_d == S_FILL_LO) || (state_d == S_FILL_HI);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE_ADDR;
            wcnt_q     <= '0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cyc_q      <= 1'b0;
            sel_q      <= 4'h0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
            sel_q      <= sel_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign cyc_i       = cyc_q;
    assign stb_i       = cyc_q;
    assign we_i        = cyc_q;
    assign sel_i       = sel_q;
    assign addr_i      = addr_q;
    assign data_i      = pk_word;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

    logic unused_ok;
    assign unused_ok = ^{data_o, stall_o, pk_phase};

endmodule

// File: tb/tb_usb_sdram_writer.sv
// Directed bench for usb_sdram_writer: reset, single word, starvation, stale ack, mid-cycle reset, full frame, timeout.
module tb_usb_sdram_writer;
    import usb_sdram_pkg::*;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, cyc_i, stb_i, we_i, busy, done, err;
    logic [3:0]  sel_i, dbg_state;
    logic [31:0] addr_i, data_i;
    logic        sdram_ack;
    logic        slave_auto = 1'b1;
    logic        man_ack = 1'b0;
    logic        auto_ack = 1'b0;

    int n_vec = 0;
    int n_miss = 0;

    // Bus monitor log: one {addr, data} entry per completed (non-reset) bus cycle.
    logic [63:0] wr_log[$];
    logic [63:0] exp_q[$];
    logic [63:0] pend = '0;
    int          n_cyc_rise = 0;
    logic        cyc_prev = 1'b0;
    logic        cyc_seen = 1'b0;

    always #5 CLK = ~CLK;

    assign sdram_ack = slave_auto ? auto_ack : man_ack;

    usb_sdram_writer #(
        .BASE_ADDR  (32'd0),
        .WORD_COUNT (120),
        .TIMEOUT    (64)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .we_i        (we_i),
        .sel_i       (sel_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (32'hDEAD_BEEF),
        .stall_o     (1'b0),
        .sdram_ack   (sdram_ack),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    // SDRAM slave model: ack one cycle after it first sees cyc/stb, one-cycle pulse.
    always @(negedge CLK) begin
        if (cyc_i && !cyc_prev) n_cyc_rise++;
        if (cyc_prev && !cyc_i && !rst) wr_log.push_back(pend);
        if (cyc_i) pend = {addr_i, data_i};
        auto_ack = cyc_i && stb_i && cyc_seen && !auto_ack;
        cyc_seen = cyc_i && stb_i;
        cyc_prev = cyc_i;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_hw(input logic [15:0] v);
        bit acc;
        bit hit;
        hit = 0;
        in_valid = 1'b1;
        in_data  = v;
        for (int k = 0; k < 200; k++) begin
            acc = in_ready;
            @(negedge CLK);
            if (acc) begin
                hit = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!hit) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_hw: half-word %h never accepted (in_ready stuck 0)", v);
        end
    endtask

    task automatic wait_cyc(input logic lvl, input string tag);
        bit hit;
        hit = 0;
        for (int k = 0; k < 200; k++) begin
            if (cyc_i === lvl) begin
                hit = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!hit) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: cyc_i never became %0b", tag, lvl);
        end
    endtask

    task automatic wait_ready(input string tag);
        bit hit;
        hit = 0;
        for (int k = 0; k < 50; k++) begin
            if (in_ready === 1'b1) begin
                hit = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!hit) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: in_ready never rose", tag);
        end
    endtask

    task automatic test_reset;
        tick(2);
        n_vec++;
        if ({in_ready, cyc_i, stb_i, we_i, busy, done, err} !== 7'b0) begin
            n_miss++;
            $display("FAIL reset_flags: got %b want 0000000", {in_ready, cyc_i, stb_i, we_i, busy, done, err});
        end
        n_vec++;
        if (sel_i !== 4'h0 || addr_i !== 32'd0 || data_i !== 32'd0) begin
            n_miss++;
            $display("FAIL reset_bus: sel=%h addr=%h data=%h want all 0", sel_i, addr_i, data_i);
        end
        n_vec++;
        if (dbg_state !== S_IDLE) begin
            n_miss++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single_word;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send_hw(16'h1111);
        send_hw(16'h2222);
        wait_cyc(1'b1, "single_cyc_rise");
        n_vec++;
        if (addr_i !== 32'd0 || data_i !== 32'h2222_1111) begin
            n_miss++;
            $display("FAIL single_bus: addr=%h data=%h want 00000000 22221111", addr_i, data_i);
        end
        n_vec++;
        if (sel_i !== 4'hF || stb_i !== 1'b1 || we_i !== 1'b1) begin
            n_miss++;
            $display("FAIL single_ctrl: sel=%h stb=%b we=%b want f 1 1", sel_i, stb_i, we_i);
        end
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_miss++;
            $display("FAIL single_flags: busy=%b in_ready=%b done=%b want 1 0 0", busy, in_ready, done);
        end
        wait_cyc(1'b0, "single_cyc_fall");
        tick(1);
        n_vec++;
        if (wr_log.size() != 1 || wr_log[0] !== {32'd0, 32'h2222_1111}) begin
            n_miss++;
            $display("FAIL single_write: count=%0d first=%h want 1 %h", wr_log.size(), wr_log[0], {32'd0, 32'h2222_1111});
        end
    endtask

    task automatic test_starvation;
        wait_ready("starve_ready");
        in_valid = 1'b1;
        in_data  = 16'h3333;
        tick(1);
        in_valid = 1'b0;
        start    = 1'b1;
        n_vec++;
        if (in_ready !== 1'b1 || cyc_i !== 1'b0 || dbg_state !== S_FILL_HI) begin
            n_miss++;
            $display("FAIL starve_gap1: in_ready=%b cyc=%b state=%0d want 1 0 %0d", in_ready, cyc_i, dbg_state, S_FILL_HI);
        end
        tick(1);
        start = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || cyc_i !== 1'b0 || dbg_state !== S_FILL_HI || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL starve_gap2: in_ready=%b cyc=%b state=%0d busy=%b want 1 0 %0d 1", in_ready, cyc_i, dbg_state, S_FILL_HI, busy);
        end
        send_hw(16'h4444);
        wait_cyc(1'b1, "starve_cyc_rise");
        wait_cyc(1'b0, "starve_cyc_fall");
        tick(1);
        n_vec++;
        if (wr_log.size() != 2 || wr_log[1] !== {32'd1, 32'h4444_3333}) begin
            n_miss++;
            $display("FAIL starve_write: count=%0d entry=%h want 2 %h", wr_log.size(), wr_log[1], {32'd1, 32'h4444_3333});
        end
    endtask

    task automatic test_stale_ack;
        wait_ready("stale_ready");
        slave_auto = 1'b0;
        man_ack    = 1'b0;
        send_hw(16'h5555);
        send_hw(16'h6666);
        man_ack = 1'b1;
        tick(1);
        n_vec++;
        if (cyc_i !== 1'b1) begin
            n_miss++;
            $display("FAIL stale_cyc_up: cyc=%b want 1", cyc_i);
        end
        tick(1);
        n_vec++;
        if (cyc_i !== 1'b1 || dbg_state !== S_WAIT_ACK) begin
            n_miss++;
            $display("FAIL stale_hold: cyc=%b state=%0d want 1 %0d", cyc_i, dbg_state, S_WAIT_ACK);
        end
        man_ack = 1'b0;
        tick(1);
        n_vec++;
        if (cyc_i !== 1'b1) begin
            n_miss++;
            $display("FAIL stale_low_ack: cyc=%b want 1", cyc_i);
        end
        man_ack = 1'b1;
        tick(1);
        n_vec++;
        if (cyc_i !== 1'b0 || dbg_state !== S_RECOVER || addr_i !== 32'd3) begin
            n_miss++;
            $display("FAIL stale_complete: cyc=%b state=%0d addr=%h want 0 %0d 3", cyc_i, dbg_state, addr_i, S_RECOVER);
        end
        tick(1);
        man_ack    = 1'b0;
        slave_auto = 1'b1;
        send_hw(16'h7777);
        send_hw(16'h8888);
        wait_cyc(1'b1, "stale_next_rise");
        wait_cyc(1'b0, "stale_next_fall");
        tick(1);
        n_vec++;
        if (wr_log.size() != 4 || wr_log[2] !== {32'd2, 32'h6666_5555} || wr_log[3] !== {32'd3, 32'h8888_7777}) begin
            n_miss++;
            $display("FAIL stale_writes: count=%0d e2=%h e3=%h want 4 %h %h", wr_log.size(), wr_log[2], wr_log[3],
                     {32'd2, 32'h6666_5555}, {32'd3, 32'h8888_7777});
        end
    endtask

    task automatic test_reset_mid_cycle;
        wait_ready("rstmid_ready");
        slave_auto = 1'b0;
        man_ack    = 1'b0;
        send_hw(16'h9999);
        send_hw(16'hAAAA);
        wait_cyc(1'b1, "rstmid_cyc_rise");
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (cyc_i !== 1'b0 || stb_i !== 1'b0 || sel_i !== 4'h0 || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL rstmid_async: cyc=%b stb=%b sel=%h busy=%b want 0 0 0 0", cyc_i, stb_i, sel_i, busy);
        end
        n_vec++;
        if (dbg_state !== S_IDLE || data_i !== 32'd0 || addr_i !== 32'd0) begin
            n_miss++;
            $display("FAIL rstmid_clear: state=%0d data=%h addr=%h want %0d 0 0", dbg_state, data_i, addr_i, S_IDLE);
        end
        tick(2);
        rst        = 1'b0;
        slave_auto = 1'b1;
        tick(1);
    endtask

    task automatic test_full_frame;
        int base_idx;
        int rise0;
        bit hit;
        base_idx = wr_log.size();
        rise0    = n_cyc_rise;
        exp_q.delete();
        for (int n = 0; n < 120; n++) exp_q.push_back({32'(n), 16'(2 * n + 1), 16'(2 * n)});
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 240; i++) send_hw(16'(i));
        hit = 0;
        for (int k = 0; k < 50; k++) begin
            if (done === 1'b1) begin
                hit = 1;
                break;
            end
            tick(1);
        end
        n_vec++;
        if (!hit || busy !== 1'b0 || dbg_state !== S_DONE) begin
            n_miss++;
            $display("FAIL frame_done: done=%b busy=%b state=%0d want 1 0 %0d", done, busy, dbg_state, S_DONE);
        end
        tick(1);
        n_vec++;
        if (done !== 1'b1 || dbg_state !== S_IDLE) begin
            n_miss++;
            $display("FAIL frame_sticky: done=%b state=%0d want 1 %0d", done, dbg_state, S_IDLE);
        end
        n_vec++;
        if (n_cyc_rise - rise0 != 120 || wr_log.size() - base_idx != 120) begin
            n_miss++;
            $display("FAIL frame_count: cyc_rises=%0d writes=%0d want 120 120", n_cyc_rise - rise0, wr_log.size() - base_idx);
        end
        for (int n = 0; n < 120 && base_idx + n < wr_log.size(); n++) begin
            n_vec++;
            if (wr_log[base_idx + n] !== exp_q[n]) begin
                n_miss++;
                $display("FAIL frame_word[%0d]: got %h want %h", n, wr_log[base_idx + n], exp_q[n]);
            end
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b1 || dbg_state !== S_FILL_LO) begin
            n_miss++;
            $display("FAIL restart_clear: done=%b busy=%b state=%0d want 0 1 %0d", done, busy, dbg_state, S_FILL_LO);
        end
    endtask

    task automatic test_timeout;
        int cnt;
        slave_auto = 1'b0;
        man_ack    = 1'b0;
        send_hw(16'hBBBB);
        send_hw(16'hCCCC);
        wait_cyc(1'b1, "timeout_cyc_rise");
        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (!cyc_i) break;
            cnt++;
        end
`ifdef WB_TIMEOUT_EN
        n_vec++;
        if (cnt != 64) begin
            n_miss++;
            $display("FAIL timeout_len: cyc high %0d cycles want 64", cnt);
        end
        n_vec++;
        if (err !== 1'b1 || done !== 1'b0 || dbg_state !== S_IDLE || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL timeout_flags: err=%b done=%b state=%0d busy=%b want 1 0 %0d 0", err, done, dbg_state, busy, S_IDLE);
        end
`else
        n_vec++;
        if (cnt != 101 || cyc_i !== 1'b1 || dbg_state !== S_WAIT_ACK) begin
            n_miss++;
            $display("FAIL no_timeout_wait: cyc high %0d cycles cyc=%b state=%0d want 101 1 %0d", cnt, cyc_i, dbg_state, S_WAIT_ACK);
        end
        n_vec++;
        if (err !== 1'b0 || done !== 1'b0) begin
            n_miss++;
            $display("FAIL no_timeout_flags: err=%b done=%b want 0 0", err, done);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_starvation();
        test_stale_ack();
        test_reset_mid_cycle();
        test_full_frame();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
